// File: rtl/ex_alu.sv
// Execute stage: single-cycle integer ALU, branch/jump resolution and an
// iterative 32-step shift-add multiplier that stalls the front end while busy.
module ex_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  inst_type,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [31:0] op1_jump,
  input  logic [31:0] op2_jump,
  input  logic        wr_reg_en,
  input  logic [4:0]  wr_reg_addr,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_inst,
  output logic [31:0] reg_wdata_o,
  output logic        alu_wr_reg_en_o,
  output logic [4:0]  alu_wr_reg_addr_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o
);

  localparam logic [2:0] T_NOP    = 3'd0;
  localparam logic [2:0] T_IALU   = 3'd1;
  localparam logic [2:0] T_RALU   = 3'd2;
  localparam logic [2:0] T_MULJMP = 3'd3;
  localparam logic [2:0] T_BRANCH = 3'd4;

  localparam logic [6:0] OPC_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [4:0]  cnt_q;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        alt;
  logic [4:0]  shamt;
  logic        accept;
  logic        wr_ok;

  assign opcode = ex_inst[6:0];
  assign funct3 = ex_inst[14:12];
  assign funct7 = ex_inst[31:25];
  assign alt    = ex_inst[30];
  assign shamt  = op2[4:0];

  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_valid && in_ready;
  assign wr_ok    = wr_reg_en && (wr_reg_addr != 5'd0);

  // Shared comparison and adder results
  logic        lt_s;
  logic        lt_u;
  logic        eq;
  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] jump_sum;

  assign lt_s     = $signed(op1) < $signed(op2);
  assign lt_u     = op1 < op2;
  assign eq       = (op1 == op2);
  assign add_res  = op1 + op2;
  assign sub_res  = op1 - op2;
  assign jump_sum = op1_jump + op2_jump;

  // Shared shifter results
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;

  assign sll_res = op1 << shamt;
  assign srl_res = op1 >> shamt;
  assign sra_res = $unsigned($signed(op1) >>> shamt);

  // Instruction decode and single-cycle result
  logic [31:0] alu_res;
  logic        alu_wr;
  logic        is_mul;
  logic        do_jump;
  logic [31:0] jump_target;
  logic        br_taken;
  logic        mul_enc;

  assign mul_enc = (opcode == OPC_OP) && (funct7 == F7_MULDIV) && !funct3[2];

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = eq;
      3'b001:  br_taken = !eq;
      3'b100:  br_taken = lt_s;
      3'b101:  br_taken = !lt_s;
      3'b110:  br_taken = lt_u;
      3'b111:  br_taken = !lt_u;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    alu_res     = 32'd0;
    alu_wr      = 1'b0;
    is_mul      = 1'b0;
    do_jump     = 1'b0;
    jump_target = jump_sum;
    case (inst_type)
      T_IALU: begin
        if (opcode == OPC_IMM) begin
          alu_wr = 1'b1;
          case (funct3)
            3'b000:  alu_res = add_res;
            3'b001:  alu_res = sll_res;
            3'b010:  alu_res = {31'd0, lt_s};
            3'b011:  alu_res = {31'd0, lt_u};
            3'b100:  alu_res = op1 ^ op2;
            3'b101:  alu_res = alt ? sra_res : srl_res;
            3'b110:  alu_res = op1 | op2;
            default: alu_res = op1 & op2;
          endcase
        end
      end
      T_RALU: begin
        if (opcode == OPC_OP && (funct7 == F7_BASE || funct7 == F7_ALT)) begin
          alu_wr = 1'b1;
          case (funct3)
            3'b000:  alu_res = alt ? sub_res : add_res;
            3'b001:  alu_res = sll_res;
            3'b010:  alu_res = {31'd0, lt_s};
            3'b011:  alu_res = {31'd0, lt_u};
            3'b100:  alu_res = op1 ^ op2;
            3'b101:  alu_res = alt ? sra_res : srl_res;
            3'b110:  alu_res = op1 | op2;
            default: alu_res = op1 & op2;
          endcase
        end else if (mul_enc) begin
          is_mul = 1'b1;
        end
      end
      T_MULJMP: begin
        if (opcode == OPC_JAL) begin
          alu_res = add_res;
          alu_wr  = 1'b1;
          do_jump = 1'b1;
        end else if (opcode == OPC_JALR) begin
          alu_res     = add_res;
          alu_wr      = 1'b1;
          do_jump     = 1'b1;
          jump_target = {jump_sum[31:1], 1'b0};
        end else if (mul_enc) begin
          is_mul = 1'b1;
        end
      end
      T_BRANCH: begin
        do_jump = br_taken;
      end
      default: begin
        alu_wr = 1'b0;
      end
    endcase
  end

  // Operand magnitudes: MULH treats both operands as signed, MULHSU only op1.
  // MUL keeps the raw bits since the low word is sign-agnostic.
  logic        op1_signed;
  logic        op2_signed;
  logic        op1_neg;
  logic        op2_neg;
  logic [31:0] op1_mag;
  logic [31:0] op2_mag;

  assign op1_signed = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
  assign op2_signed = (funct3[1:0] == 2'b01);
  assign op1_neg    = op1_signed && op1[31];
  assign op2_neg    = op2_signed && op2[31];
  assign op1_mag    = op1_neg ? (~op1 + 32'd1) : op1;
  assign op2_mag    = op2_neg ? (~op2 + 32'd1) : op2;

  logic [63:0] mcand_q;
  logic [31:0] mplier_q;
  logic [63:0] prod_q;
  logic        m_neg_q;
  logic        m_hi_q;
  logic [4:0]  m_rd_q;
  logic        m_wr_q;
  logic [63:0] prod_fixed;

  assign prod_fixed = m_neg_q ? (~prod_q + 64'd1) : prod_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_BUSY;
      S_BUSY:  if (cnt_q == 5'd31) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Multiplier datapath; a 64-bit accumulator avoids a separate carry stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 5'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      prod_q   <= 64'd0;
      m_neg_q  <= 1'b0;
      m_hi_q   <= 1'b0;
      m_rd_q   <= 5'd0;
      m_wr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= 5'd0;
          if (accept && is_mul) begin
            mcand_q  <= {32'd0, op1_mag};
            mplier_q <= op2_mag;
            prod_q   <= 64'd0;
            m_neg_q  <= op1_neg ^ op2_neg;
            m_hi_q   <= (funct3[1:0] != 2'b00);
            m_rd_q   <= wr_reg_addr;
            m_wr_q   <= wr_ok;
          end
        end
        S_BUSY: begin
          if (mplier_q[0]) prod_q <= prod_q + mcand_q;
          mcand_q  <= {mcand_q[62:0], 1'b0};
          mplier_q <= {1'b0, mplier_q[31:1]};
          cnt_q    <= cnt_q + 5'd1;
        end
        default: cnt_q <= 5'd0;
      endcase
    end
  end

  // Output registers: pulses default low, data holds unless a write lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_wdata_o       <= 32'd0;
      alu_wr_reg_en_o   <= 1'b0;
      alu_wr_reg_addr_o <= 5'd0;
      jump_flag_o       <= 1'b0;
      jump_addr_o       <= 32'd0;
    end else begin
      alu_wr_reg_en_o <= 1'b0;
      jump_flag_o     <= 1'b0;
      if (state_q == S_IDLE && accept && !is_mul) begin
        if (alu_wr && wr_ok) begin
          reg_wdata_o       <= alu_res;
          alu_wr_reg_addr_o <= wr_reg_addr;
          alu_wr_reg_en_o   <= 1'b1;
        end
        if (do_jump) begin
          jump_flag_o <= 1'b1;
          jump_addr_o <= jump_target;
        end
      end else if (state_q == S_DONE && m_wr_q) begin
        reg_wdata_o       <= m_hi_q ? prod_fixed[63:32] : prod_fixed[31:0];
        alu_wr_reg_addr_o <= m_rd_q;
        alu_wr_reg_en_o   <= 1'b1;
      end
    end
  end

  // ex_pc is carried for debug visibility only; jump bases arrive pre-selected
  logic unused_ok;
  assign unused_ok = ^ex_pc;

endmodule

// File: tb/tb_ex_alu.sv
// Directed bench for ex_alu: hand-computed vectors, write-back scoreboard
// and a single check task feeding the summary counters.
module tb_ex_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  inst_type;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] op1_jump;
  logic [31:0] op2_jump;
  logic        wr_reg_en;
  logic [4:0]  wr_reg_addr;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic [31:0] reg_wdata_o;
  logic        alu_wr_reg_en_o;
  logic [4:0]  alu_wr_reg_addr_o;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  localparam logic [6:0] OPC_IMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP   = 7'b0110011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BR   = 7'b1100011;

  ex_alu dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .inst_type         (inst_type),
    .op1               (op1),
    .op2               (op2),
    .op1_jump          (op1_jump),
    .op2_jump          (op2_jump),
    .wr_reg_en         (wr_reg_en),
    .wr_reg_addr       (wr_reg_addr),
    .ex_pc             (ex_pc),
    .ex_inst           (ex_inst),
    .reg_wdata_o       (reg_wdata_o),
    .alu_wr_reg_en_o   (alu_wr_reg_en_o),
    .alu_wr_reg_addr_o (alu_wr_reg_addr_o),
    .jump_flag_o       (jump_flag_o),
    .jump_addr_o       (jump_addr_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
    return {f7, 10'd0, f3, 5'd0, opc};
  endfunction

  // scoreboard: every write-back pulse must match the next queued value
  always @(negedge clk) begin
    if (rst_n && alu_wr_reg_en_o) begin
      if (exp_q.size() == 0) check("sb_unexpected_wr", {27'd0, alu_wr_reg_addr_o}, 32'hDEAD);
      else check("sb_wdata", reg_wdata_o, exp_q.pop_front());
    end
  end

  task automatic drive(input logic [2:0] t, input logic [31:0] inst, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ja, input logic [31:0] jb,
                       input logic [4:0] rd, input logic we);
    @(negedge clk);
    in_valid    = 1'b1;
    inst_type   = t;
    ex_inst     = inst;
    op1         = a;
    op2         = b;
    op1_jump    = ja;
    op2_jump    = jb;
    wr_reg_addr = rd;
    wr_reg_en   = we;
    ex_pc       = ja;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic alu_op(input string tag, input logic [2:0] t, input logic [31:0] inst,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp);
    exp_q.push_back(exp);
    drive(t, inst, a, b, 32'd0, 32'd0, rd, 1'b1);
    check({tag, "_en"}, {31'd0, alu_wr_reg_en_o}, 32'd1);
    check({tag, "_data"}, reg_wdata_o, exp);
    check({tag, "_addr"}, {27'd0, alu_wr_reg_addr_o}, {27'd0, rd});
    @(posedge clk);
    #1;
    check({tag, "_en_drop"}, {31'd0, alu_wr_reg_en_o}, 32'd0);
    check({tag, "_hold"}, reg_wdata_o, exp);
  endtask

  task automatic mul_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int n;
    exp_q.push_back(exp);
    drive(3'd3, mk(OPC_OP, f3, 7'b0000001), a, b, 32'd0, 32'd0, rd, 1'b1);
    check({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    // in_valid held high with different operands while busy must be ignored
    in_valid = 1'b1; inst_type = 3'd2; ex_inst = mk(OPC_OP, 3'b000, 7'd0);
    op1 = 32'h123; op2 = 32'h7; wr_reg_addr = 5'd9; wr_reg_en = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, n, 33);
    check({tag, "_en"}, {31'd0, alu_wr_reg_en_o}, 32'd1);
    check({tag, "_data"}, reg_wdata_o, exp);
    check({tag, "_addr"}, {27'd0, alu_wr_reg_addr_o}, {27'd0, rd});
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; inst_type = 3'd0; op1 = 32'd0; op2 = 32'd0;
    op1_jump = 32'd0; op2_jump = 32'd0; wr_reg_en = 1'b0; wr_reg_addr = 5'd0;
    ex_pc = 32'd0; ex_inst = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_en", {31'd0, alu_wr_reg_en_o}, 32'd0);
    check("rst_wdata", reg_wdata_o, 32'd0);
    check("rst_jflag", {31'd0, jump_flag_o}, 32'd0);
    check("rst_jaddr", jump_addr_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    alu_op("addi", 3'd1, mk(OPC_IMM, 3'b000, 7'd0), 32'd5, 32'hFFFF_FFFD, 5'd3, 32'd2);
    alu_op("sra", 3'd2, mk(OPC_OP, 3'b101, 7'b0100000), 32'h8000_0000, 32'd4, 5'd5, 32'hF800_0000);
    alu_op("srl", 3'd2, mk(OPC_OP, 3'b101, 7'd0), 32'h8000_0000, 32'd4, 5'd5, 32'h0800_0000);
    alu_op("sub", 3'd2, mk(OPC_OP, 3'b000, 7'b0100000), 32'd5, 32'd7, 5'd6, 32'hFFFF_FFFE);
    alu_op("slt", 3'd2, mk(OPC_OP, 3'b010, 7'd0), 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd1);
    alu_op("sltu", 3'd2, mk(OPC_OP, 3'b011, 7'd0), 32'hFFFF_FFFF, 32'd1, 5'd6, 32'd0);
    alu_op("slli", 3'd1, mk(OPC_IMM, 3'b001, 7'd0), 32'h0000_0003, 32'd31, 5'd8, 32'h8000_0000);

    // BLT taken, no write
    drive(3'd4, mk(OPC_BR, 3'b100, 7'd0), 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd0, 1'b0);
    check("blt_flag", {31'd0, jump_flag_o}, 32'd1);
    check("blt_addr", jump_addr_o, 32'h120);
    check("blt_nowr", {31'd0, alu_wr_reg_en_o}, 32'd0);
    @(posedge clk);
    #1;
    check("blt_flag_drop", {31'd0, jump_flag_o}, 32'd0);

    // BLTU not taken
    drive(3'd4, mk(OPC_BR, 3'b110, 7'd0), 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 5'd0, 1'b0);
    check("bltu_flag", {31'd0, jump_flag_o}, 32'd0);

    // JALR clears bit 0 of the target; JAL does not
    exp_q.push_back(32'h44);
    drive(3'd3, mk(OPC_JALR, 3'b000, 7'd0), 32'h40, 32'd4, 32'h1001, 32'd2, 5'd1, 1'b1);
    check("jalr_data", reg_wdata_o, 32'h44);
    check("jalr_flag", {31'd0, jump_flag_o}, 32'd1);
    check("jalr_addr", jump_addr_o, 32'h1002);
    exp_q.push_back(32'h48);
    drive(3'd3, mk(OPC_JAL, 3'b000, 7'd0), 32'h44, 32'd4, 32'h1001, 32'd2, 5'd2, 1'b1);
    check("jal_data", reg_wdata_o, 32'h48);
    check("jal_addr", jump_addr_o, 32'h1003);

    // rd = 0 suppressed, data holds
    drive(3'd2, mk(OPC_OP, 3'b000, 7'd0), 32'd1, 32'd2, 32'd0, 32'd0, 5'd0, 1'b1);
    check("rd0_en", {31'd0, alu_wr_reg_en_o}, 32'd0);
    check("rd0_hold", reg_wdata_o, 32'h48);

    // DIV decodes as nop
    drive(3'd3, mk(OPC_OP, 3'b100, 7'b0000001), 32'd10, 32'd2, 32'd0, 32'd0, 5'd4, 1'b1);
    check("div_nop_en", {31'd0, alu_wr_reg_en_o}, 32'd0);
    check("div_nop_ready", {31'd0, in_ready}, 32'd1);

    mul_op("mulh", 3'b001, 32'hFFFF_FFFE, 32'd3, 5'd7, 32'hFFFF_FFFF);
    mul_op("mul", 3'b000, 32'hFFFF_FFFE, 32'd3, 5'd7, 32'hFFFF_FFFA);
    mul_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE);
    // back-to-back accept right after the multiply result
    alu_op("post_mul", 3'd1, mk(OPC_IMM, 3'b110, 7'd0), 32'h0F0, 32'h00F, 5'd11, 32'h0FF);

    // reset in the middle of a multiply
    drive(3'd3, mk(OPC_OP, 3'b000, 7'b0000001), 32'd6, 32'd7, 32'd0, 32'd0, 5'd12, 1'b1);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_wdata", reg_wdata_o, 32'd0);
    check("mrst_addr", {27'd0, alu_wr_reg_addr_o}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("mrst_nowr", {31'd0, alu_wr_reg_en_o}, 32'd0);
    check("mrst_ready2", {31'd0, in_ready}, 32'd1);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
